// File: rtl/wb_arbiter_pkg.sv
// Shared types for the writeback arbiter: the result record carried by slots,
// execution units and the writeback bus, plus default widths.
package wb_arbiter_pkg;

    localparam int DataWidth = 32;
    localparam int RobDepth  = 16;
    localparam int ReqNum    = 4;
    localparam int RobW      = $clog2(RobDepth);
    localparam int ExpCodeW  = 4;

    typedef struct packed {
        logic [RobW-1:0] addr;
    } RegFile_t;

    typedef logic [ExpCodeW-1:0] ExpCode_t;

    typedef struct packed {
        RegFile_t               rd;
        logic [DataWidth-1:0]   data;
        logic                   exp_;
        ExpCode_t               exp_code;
        logic                   pred_miss_;
        logic                   jump_miss_;
    } WbReq_t;

endpackage

// File: rtl/wb_arb_pick.sv
// Combinational one-hot picker: first asserted candidate found searching
// upward from start, wrapping at N.
module wb_arb_pick #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  cand,
    input  logic [IW-1:0] start,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] grant_idx,
    output logic          any
);

    int          pos;
    logic [IW-1:0] p;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        any       = 1'b0;
        pos       = 0;
        p         = '0;
        for (int k = 0; k < N; k++) begin
            pos = int'(start) + k;
            if (pos >= N) pos = pos - N;
            p = IW'(pos);
            if (!any && cand[p]) begin
                any       = 1'b1;
                grant[p]  = 1'b1;
                grant_idx = p;
            end
        end
    end

endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: REQ execution units share one registered ROB writeback port.
// Define WB_ARB_RR_EN for round-robin; otherwise fixed priority, index 0 highest.
module wb_arbiter
    import wb_arbiter_pkg::*;
#(
    parameter int DATA      = DataWidth,
    parameter int ROB_DEPTH = RobDepth,
    parameter int REQ       = ReqNum,
    localparam int ROB      = $clog2(ROB_DEPTH),
    localparam int IW       = (REQ > 1) ? $clog2(REQ) : 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      flush_,
    input  logic [REQ-1:0]            req_e_,
    input  RegFile_t [REQ-1:0]        req_rd,
    input  logic [REQ-1:0][DATA-1:0]  req_data,
    input  logic [REQ-1:0]            req_exp_,
    input  ExpCode_t [REQ-1:0]        req_exp_code,
    input  logic [REQ-1:0]            req_pred_miss_,
    input  logic [REQ-1:0]            req_jump_miss_,
    output logic [REQ-1:0]            req_busy,
    output logic                      wb_e_,
    output RegFile_t                  wb_rd,
    output logic [DATA-1:0]           wb_data,
    output logic                      wb_exp_,
    output ExpCode_t                  wb_exp_code,
    output logic                      wb_pred_miss_,
    output logic                      wb_jump_miss_
);

    // Handshake: req_e_ low presents a result for one cycle; it is accepted
    // unconditionally unless req_busy is high, in which case the requester
    // must stall and any strobe is ignored.

    WbReq_t         slot_q   [REQ];
    logic [REQ-1:0] slot_valid;
    WbReq_t         in_req   [REQ];
    WbReq_t         cand_req [REQ];
    logic [REQ-1:0] in_valid;
    logic [REQ-1:0] cand;
    logic [REQ-1:0] grant;
    logic [IW-1:0]  grant_idx;
    logic           any;
    logic [IW-1:0]  start;
    logic [ROB-1:0] grant_rob;

    assign req_busy = slot_valid;

    // A held slot always outranks its own requester's new result.
    always_comb begin
        for (int i = 0; i < REQ; i++) begin
            in_req[i].rd         = req_rd[i];
            in_req[i].data       = req_data[i];
            in_req[i].exp_       = req_exp_[i];
            in_req[i].exp_code   = req_exp_code[i];
            in_req[i].pred_miss_ = req_pred_miss_[i];
            in_req[i].jump_miss_ = req_jump_miss_[i];
            in_valid[i]          = !req_e_[i] && !slot_valid[i];
            cand[i]              = slot_valid[i] || in_valid[i];
            cand_req[i]          = slot_valid[i] ? slot_q[i] : in_req[i];
        end
    end

`ifdef WB_ARB_RR_EN
    logic [IW-1:0] last_grant;

    assign start = (last_grant == IW'(REQ - 1)) ? '0 : last_grant + 1'b1;

    always_ff @(posedge clk) begin
        if (reset)
            last_grant <= '0;
        else if (flush_ && any)
            last_grant <= grant_idx;
    end
`else
    assign start = '0;
`endif

    wb_arb_pick #(.N(REQ), .IW(IW)) u_pick (
        .cand      (cand),
        .start     (start),
        .grant     (grant),
        .grant_idx (grant_idx),
        .any       (any)
    );

    assign grant_rob = cand_req[grant_idx].rd.addr;

    always_ff @(posedge clk) begin
        if (reset) begin
            slot_valid    <= '0;
            for (int i = 0; i < REQ; i++) slot_q[i] <= '0;
            wb_e_         <= 1'b1;
            wb_rd         <= '0;
            wb_data       <= '0;
            wb_exp_       <= 1'b1;
            wb_exp_code   <= '0;
            wb_pred_miss_ <= 1'b1;
            wb_jump_miss_ <= 1'b1;
        end else if (!flush_) begin
            slot_valid    <= '0;
            wb_e_         <= 1'b1;
            wb_exp_       <= 1'b1;
            wb_pred_miss_ <= 1'b1;
            wb_jump_miss_ <= 1'b1;
        end else begin
            for (int i = 0; i < REQ; i++) begin
                if (slot_valid[i] && grant[i]) begin
                    slot_valid[i] <= 1'b0;
                end else if (in_valid[i] && !grant[i]) begin
                    slot_valid[i] <= 1'b1;
                    slot_q[i]     <= in_req[i];
                end
            end
            if (any) begin
                wb_e_         <= 1'b0;
                wb_rd         <= '{addr: grant_rob};
                wb_data       <= cand_req[grant_idx].data;
                wb_exp_       <= cand_req[grant_idx].exp_;
                wb_exp_code   <= cand_req[grant_idx].exp_code;
                wb_pred_miss_ <= cand_req[grant_idx].pred_miss_;
                wb_jump_miss_ <= cand_req[grant_idx].jump_miss_;
            end else begin
                wb_e_         <= 1'b1;
                wb_exp_       <= 1'b1;
                wb_pred_miss_ <= 1'b1;
                wb_jump_miss_ <= 1'b1;
            end
        end
    end

    a_no_req_while_busy: assert property (@(posedge clk) disable iff (reset)
        ((~req_e_ & req_busy) == '0));

endmodule
